// File: rtl/piano_pkg.sv
// Shared constants for the piano note capture path.
// Note width, empty-slot code and key-index to note-code mapping.
package piano_pkg;

  localparam int NOTE_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_EMPTY = 4'h0;

  // Code 0 marks an empty slot, so key i shows as i+1.
  function automatic logic [NOTE_W-1:0] note_of(input int idx);
    logic [NOTE_W-1:0] c;
    c = NOTE_W'(idx + 1);
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, stable-count debounce, press pulse.
// Ports: clk, reset, i_key (raw, async) -> o_rise (one-cycle press pulse).
module key_debounce #(
  parameter int DB_COUNT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key,
  output logic o_rise
);

  localparam int CW = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_key;
      r_sync <= r_meta;
      r_db_d <= r_db;
      // Any return to the accepted level restarts the count.
      if (r_sync == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_db  <= r_sync;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_rise = r_db & ~r_db_d;

endmodule

// File: rtl/note_history.sv
// Debounced piano keys feeding a four-deep note history for the display.
// Ports: clk, reset, key[], clear -> note_valid, note_code, in0..in3.
module note_history
  import piano_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter int DB_COUNT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_KEYS-1:0] key,
  input  logic              clear,
  output logic              note_valid,
  output logic [NOTE_W-1:0] note_code,
  output logic [NOTE_W-1:0] in0,
  output logic [NOTE_W-1:0] in1,
  output logic [NOTE_W-1:0] in2,
  output logic [NOTE_W-1:0] in3
);

  logic [NUM_KEYS-1:0] w_rise;
  logic                w_hit;
  logic [NOTE_W-1:0]   w_code;

  logic              r_valid;
  logic [NOTE_W-1:0] r_code;
  logic [NOTE_W-1:0] r_in0;
  logic [NOTE_W-1:0] r_in1;
  logic [NOTE_W-1:0] r_in2;
  logic [NOTE_W-1:0] r_in3;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_COUNT(DB_COUNT)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .i_key (key[g]),
      .o_rise(w_rise[g])
    );
  end

  // Scan high to low so the lowest simultaneous press wins.
  always_comb begin
    w_hit  = 1'b0;
    w_code = NOTE_EMPTY;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_hit  = 1'b1;
        w_code = note_of(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_code  <= NOTE_EMPTY;
      r_in0   <= NOTE_EMPTY;
      r_in1   <= NOTE_EMPTY;
      r_in2   <= NOTE_EMPTY;
      r_in3   <= NOTE_EMPTY;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_in0   <= NOTE_EMPTY;
      r_in1   <= NOTE_EMPTY;
      r_in2   <= NOTE_EMPTY;
      r_in3   <= NOTE_EMPTY;
    end else begin
      r_valid <= w_hit;
      if (w_hit) begin
        r_code <= w_code;
        r_in3  <= r_in2;
        r_in2  <= r_in1;
        r_in1  <= r_in0;
        r_in0  <= w_code;
      end
    end
  end

  assign note_valid = r_valid;
  assign note_code  = r_code;
  assign in0        = r_in0;
  assign in1        = r_in1;
  assign in2        = r_in2;
  assign in3        = r_in3;

endmodule

// File: tb/tb_note_history.sv
// Testbench for note_history with DB_COUNT = 4.
// Randomised and directed stimulus against a behavioural model.
module tb_note_history;

  localparam int NK = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [NK-1:0] key = '0;
  logic          note_valid;
  logic [3:0]    note_code;
  logic [3:0]    in0;
  logic [3:0]    in1;
  logic [3:0]    in2;
  logic [3:0]    in3;

  int errors = 0;
  int checks = 0;

  note_history #(
    .NUM_KEYS(NK),
    .DB_COUNT(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .clear     (clear),
    .note_valid(note_valid),
    .note_code (note_code),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3)
  );

  always #5 clk = ~clk;

  // Behavioural model: s is the key seen two edges late; the
  // accepted level flips once s has disagreed with it for DB
  // consecutive edges; a press is an accepted 0->1 change.
  logic [NK-1:0] m_sa;
  logic [NK-1:0] m_s;
  logic [NK-1:0] m_db;
  logic [NK-1:0] m_prev;
  int            m_streak [NK];
  int            m_win;
  logic          m_valid;
  logic [3:0]    m_code;
  logic [3:0]    m_hist [4];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sa = '0; m_s = '0; m_db = '0; m_prev = '0;
      for (int k = 0; k < NK; k++) m_streak[k] = 0;
      m_valid = 1'b0; m_code = 4'h0;
      for (int k = 0; k < 4; k++) m_hist[k] = 4'h0;
    end else begin
      m_win = -1;
      for (int k = NK - 1; k >= 0; k--)
        if (m_db[k] && !m_prev[k]) m_win = k;
      if (clear) begin
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) m_hist[k] = 4'h0;
      end else begin
        m_valid = (m_win >= 0);
        if (m_win >= 0) begin
          m_code = 4'(m_win + 1);
          m_hist[3] = m_hist[2];
          m_hist[2] = m_hist[1];
          m_hist[1] = m_hist[0];
          m_hist[0] = m_code;
        end
      end
      m_prev = m_db;
      for (int k = 0; k < NK; k++) begin
        if (m_s[k] != m_db[k]) begin
          m_streak[k]++;
          if (m_streak[k] == DB) begin
            m_db[k] = m_s[k];
            m_streak[k] = 0;
          end
        end else begin
          m_streak[k] = 0;
        end
      end
      m_s  = m_sa;
      m_sa = key;
    end
  end

  logic [20:0] dut_pack;
  logic [20:0] exp_pack;
  assign dut_pack = {note_valid, note_code, in3, in2, in1, in0};
  assign exp_pack = {m_valid, m_code, m_hist[3], m_hist[2],
                     m_hist[1], m_hist[0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (dut_pack !== 21'h0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0", dut_pack);
    end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (note_valid !== 1'b0 || dut_pack !== exp_pack) begin
        errors++;
        $display("FAIL idle got=%h exp=%h", dut_pack, exp_pack);
      end
    end
  endtask

  task automatic test_clean_press();
    int at = 0;
    int got = 0;
    key[2] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (dut_pack !== exp_pack) begin
        errors++;
        $display("FAIL press_model got=%h exp=%h", dut_pack, exp_pack);
      end
      if (note_valid === 1'b1) begin
        if (got == 0) at = i;
        got++;
      end
    end
    checks++;
    if (at != 7 || got != 1) begin
      errors++;
      $display("FAIL press_latency got=%0d/%0d exp=7/1", at, got);
    end
    checks++;
    if ({note_code, in3, in2, in1, in0} !== 20'h3_0003) begin
      errors++;
      $display("FAIL press_hist got=%h exp=30003",
               {note_code, in3, in2, in1, in0});
    end
    key[2] = 1'b0;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (note_valid === 1'b1) got++;
    end
    checks++;
    if (got != 0) begin
      errors++;
      $display("FAIL release_event got=%0d exp=0", got);
    end
  endtask

  task automatic test_bounce();
    int at = 0;
    int got = 0;
    logic [3:0] pat = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      key[0] = pat[i] ^ 1'b1 ? 1'b0 : 1'b1;
      key[0] = ~pat[i];
      step();
      if (note_valid === 1'b1) got++;
    end
    key[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (dut_pack !== exp_pack) begin
        errors++;
        $display("FAIL bounce_model got=%h exp=%h", dut_pack, exp_pack);
      end
      if (note_valid === 1'b1) begin
        if (at == 0) at = i;
        got++;
      end
    end
    checks++;
    if (at != 7 || got != 1 || note_code !== 4'd1 || in0 !== 4'd1) begin
      errors++;
      $display("FAIL bounce at=%0d n=%0d code=%0d exp=7/1/1",
               at, got, note_code);
    end
    key[0] = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 5; k++) begin
      key[k] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step();
        checks++;
        if (dut_pack !== exp_pack) begin
          errors++;
          $display("FAIL wrap_model got=%h exp=%h", dut_pack, exp_pack);
        end
      end
      key[k] = 1'b0;
      repeat (8) step();
    end
    checks++;
    if ({in0, in1, in2, in3} !== 16'h5432) begin
      errors++;
      $display("FAIL wrap_hist got=%h exp=5432", {in0, in1, in2, in3});
    end
  endtask

  task automatic test_simultaneous();
    int got = 0;
    key[5] = 1'b1;
    key[3] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (note_valid === 1'b1) got++;
    end
    checks++;
    if (got != 1 || note_code !== 4'd4 || in0 !== 4'd4) begin
      errors++;
      $display("FAIL simul got=%0d/%0d exp=1/4", got, note_code);
    end
    key[5] = 1'b0;
    repeat (10) step();
    key[5] = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (note_valid === 1'b1) got++;
    end
    checks++;
    if (got != 1 || note_code !== 4'd6 || {in0, in1} !== 8'h64) begin
      errors++;
      $display("FAIL repress got=%0d/%0d/%h exp=1/6/64",
               got, note_code, {in0, in1});
    end
    key = '0;
    repeat (10) step();
  endtask

  task automatic test_clear_event();
    int got = 0;
    key[1] = 1'b1;
    repeat (6) step();
    clear = 1'b1;
    step();
    checks++;
    if ({note_valid, in3, in2, in1, in0} !== 17'h0) begin
      errors++;
      $display("FAIL clear_evt got=%h exp=0",
               {note_valid, in3, in2, in1, in0});
    end
    clear = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (note_valid === 1'b1) got++;
    end
    checks++;
    if (got != 0 || {in3, in2, in1, in0} !== 16'h0) begin
      errors++;
      $display("FAIL clear_drop got=%0d exp=0", got);
    end
    key = '0;
    repeat (8) step();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0)
        key[$urandom_range(0, NK - 1)] ^= 1'b1;
      clear = ($urandom_range(0, 39) == 0);
      step();
      checks++;
      if (dut_pack !== exp_pack) begin
        errors++;
        if (bad < 10)
          $display("FAIL random t=%0t got=%h exp=%h",
                   $time, dut_pack, exp_pack);
        bad++;
      end
    end
    clear = 1'b0;
    key = '0;
    repeat (10) step();
  endtask

  task automatic test_reset_mid();
    int at = 0;
    key[6] = 1'b1;
    repeat (4) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dut_pack !== 21'h0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", dut_pack);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (note_valid === 1'b1 && at == 0) at = i;
    end
    checks++;
    if (at != 7 || note_code !== 4'd7 || {in3, in2, in1, in0} !== 16'h0007) begin
      errors++;
      $display("FAIL reset_held at=%0d code=%0d exp=7/7", at, note_code);
    end
    key = '0;
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_simultaneous();
    test_clear_event();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_history.md
# note_history

Captures piano key presses and presents the four most recent notes as 4-bit digit codes for the four-digit seven-segment display multiplexer. Each raw key input is synchronised and debounced, and a clean press produces a one-cycle note event. The event shifts the note into a four-deep history register. The history outputs drive the display multiplexer's four digit inputs directly, with the newest note on the rightmost digit.

## Interface
Parameters:
- NUM_KEYS, 8: number of piano keys; legal range 1..15.
- DB_COUNT, 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); minimum 2.

Ports:
- clk  in  1: system clock.
- reset  in  1: asynchronous, active-high reset.
- key  in  NUM_KEYS: raw push-buttons, asynchronous, 1 = pressed.
- clear  in  1: synchronous history clear, level-sensitive.
- note_valid  out  1: one-cycle pulse per accepted press.
- note_code  out  4: code of the accepted press, valid with note_valid.
- in0  out  4: newest note, rightmost digit.
- in1  out  4: second newest note.
- in2  out  4: third newest note.
- in3  out  4: oldest note, leftmost digit.

## Operation
- Note code = key index + 1, giving 1..NUM_KEYS. Code 4'h0 = empty slot.
- Per key, the path is:
  - Two-flop synchroniser, output s.
  - Debounced level db.
  - Counter of width $clog2(DB_COUNT).
- Debounce rule, per cycle:
  - If s == db: counter <= 0.
  - Else if counter == DB_COUNT-1: db <= s and counter <= 0.
  - Else: counter <= counter + 1.
- A bounce back to the db level before the count completes restarts the count from 0.
- Press event = db rising edge (db = 1, previous db = 0). Release generates no event.
- Several keys rising in the same cycle: the lowest index wins. The other presses are discarded permanently, because their db is already high and they cannot produce a later event.
- On the event cycle, registered on the next edge:
  - note_valid <= 1.
  - note_code <= code.
  - in3 <= in2, in2 <= in1, in1 <= in0, in0 <= code.
- When clear = 1:
  - in0..in3 <= 0 and note_valid <= 0.
  - A press event in the same cycle is dropped. Clear wins.
  - Debounce state is unaffected.
- History wraps by discarding the oldest entry. There is no full condition.

## Timing
- Reset values: in0..in3 = 4'h0, note_valid = 0, note_code = 4'h0.
- Reset values of internal state: synchronisers, db and counters are all 0, so every key is treated as released.
- Latency from the first clk edge sampling key = 1 to note_valid = 1: 2 (synchroniser) + DB_COUNT (debounce) + 1 (event register) = DB_COUNT+3 edges. The key must be stable throughout.
- History outputs update on the same edge that raises note_valid.
- note_valid is high for exactly one cycle per press, even if the key is held.
- Key held across reset deassertion: it is counted as a new press after DB_COUNT+3 edges.
- Reset asserted mid-debounce or mid-event: all state clears immediately and asynchronously. A pending event is lost.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- piano_pkg holds the shared constants:
  - NOTE_W = 4.
  - NOTE_EMPTY = 4'h0.
  - the code mapping function (index -> index+1).
- Sub-module key_debounce handles one key: synchroniser, counter, db and rising-edge pulse. note_history instantiates it NUM_KEYS times in a generate loop.
- The top level holds only the priority encoder, the event register and the history shift register.

## Test plan
All scenarios use DB_COUNT = 4.
- Reset: assert reset mid-cycle -> all outputs 0 immediately. Deassert, hold keys low for 20 cycles -> no note_valid.
- Clean press:
  - Stimulus: key[2] high for 10 cycles.
  - Response: one note_valid pulse exactly 7 edges after the first sampling edge, note_code = 3, in0 = 3, in1..in3 = 0.
  - Release: no event.
- Bounce:
  - Stimulus: key[0] toggles 1,0,1,0 on successive cycles, then stays high.
  - Response: no event during the toggling. A single event with code 1 follows 7 edges after the final rise.
- Wrap: press keys 0,1,2,3,4 in sequence -> in0..in3 = 5,4,3,2, and code 1 is discarded.
- Simultaneous and clear:
  - key[5] and key[3] rise in the same cycle -> single event with code 4. A later release and re-press of key[5] yields code 6.
  - clear asserted in the cycle of an event -> in0..in3 = 0 and note_valid = 0.
